ps2_key_decoder: RTL

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

---
 rtl/ps2_key_decoder_pkg.sv | 75 +++++++
 rtl/ps2_key_decoder_rx.sv | 97 +++++++++
 rtl/ps2_key_decoder.sv | 109 ++++++++++
 3 files changed

// File: rtl/ps2_key_decoder_pkg.sv
// Shared scancode constants, key indices and decoder states for the PS/2 key decoder.
// Also holds the scancode-to-key lookup used by the decoder FSM.
package ps2_key_decoder_pkg;

  localparam int unsigned NUM_KEYS   = 8;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned FRAME_BITS = 11;

  // Prefix and status bytes
  localparam logic [7:0] SC_EXT      = 8'hE0;
  localparam logic [7:0] SC_BRK      = 8'hF0;
  localparam logic [7:0] SC_ACK      = 8'hFA;
  localparam logic [7:0] SC_BAT_OK   = 8'hAA;
  localparam logic [7:0] SC_ERR_ZERO = 8'h00;
  localparam logic [7:0] SC_OVERRUN  = 8'hFF;

  // Key scancodes; the arrows only count when E0-prefixed
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_X     = 8'h22;
  localparam logic [7:0] SC_Z     = 8'h1A;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_C     = 8'h21;

  typedef enum logic [2:0] {
    KEY_LEFT  = 3'd0,
    KEY_RIGHT = 3'd1,
    KEY_DOWN  = 3'd2,
    KEY_UP    = 3'd3,
    KEY_X     = 3'd4,
    KEY_Z     = 3'd5,
    KEY_SPACE = 3'd6,
    KEY_C     = 3'd7
  } key_idx_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } dec_state_e;

  typedef struct packed {
    logic     hit;
    key_idx_e idx;
  } key_lookup_t;

  // Map a completed code to a key slot; extended and plain codes are distinct keys.
  function automatic key_lookup_t lookup_key(input logic ext, input logic [7:0] code);
    key_lookup_t r;
    r.hit = 1'b1;
    r.idx = KEY_LEFT;
    if (ext) begin
      case (code)
        SC_LEFT:  r.idx = KEY_LEFT;
        SC_RIGHT: r.idx = KEY_RIGHT;
        SC_DOWN:  r.idx = KEY_DOWN;
        SC_UP:    r.idx = KEY_UP;
        default:  r.hit = 1'b0;
      endcase
    end else begin
      case (code)
        SC_X:     r.idx = KEY_X;
        SC_Z:     r.idx = KEY_Z;
        SC_SPACE: r.idx = KEY_SPACE;
        SC_C:     r.idx = KEY_C;
        default:  r.hit = 1'b0;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/ps2_key_decoder_rx.sv
// PS/2 frame receiver: synchronizers, falling-edge sampling, 11-bit frame check
// and a mid-frame inactivity timeout.
module ps2_rx
  import ps2_key_decoder_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned CNT_W = 4;
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(BYTE_W);
  localparam logic [CNT_W-1:0] PAR_BIT   = CNT_W'(BYTE_W + 1);

  logic [1:0]        clk_sync;
  logic [1:0]        data_sync;
  logic              clk_prev;
  logic              sample_c;
  logic              sdata_c;
  logic [CNT_W-1:0]  bit_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [BYTE_W-1:0] shreg;
  logic              parity;

  // Two-stage synchronizers, preset high so reset looks like an idle bus
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      clk_prev  <= clk_sync[1];
    end
  end

  assign sample_c = clk_prev & ~clk_sync[1];
  assign sdata_c  = data_sync[1];

  // Bit counter walks start, 8 data bits, parity, stop; shreg fills LSB first
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt    <= '0;
      tmo_cnt    <= '0;
      shreg      <= '0;
      parity     <= 1'b0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (sample_c) begin
        tmo_cnt <= '0;
        if (bit_cnt == '0) begin
          if (!sdata_c) begin
            bit_cnt <= CNT_W'(1);
          end else begin
            frame_err <= 1'b1;
          end
        end else if (bit_cnt <= LAST_DATA) begin
          shreg   <= {sdata_c, shreg[BYTE_W-1:1]};
          bit_cnt <= bit_cnt + CNT_W'(1);
        end else if (bit_cnt == PAR_BIT) begin
          parity  <= sdata_c;
          bit_cnt <= bit_cnt + CNT_W'(1);
        end else begin
          bit_cnt <= '0;
          if (sdata_c && (^{shreg, parity})) begin
            byte_out   <= shreg;
            byte_valid <= 1'b1;
          end else begin
            frame_err <= 1'b1;
          end
        end
      end else if (bit_cnt != '0) begin
        // Silently drop a stalled partial frame
        if (tmo_cnt == TMO_LAST) begin
          bit_cnt <= '0;
          tmo_cnt <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 scancode decoder: tracks E0/F0 prefixes and maintains held-key levels
// for the game input manager.
module ps2_key_decoder
  import ps2_key_decoder_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic raw_left,
  output logic raw_right,
  output logic raw_down,
  output logic raw_rotate_cw,
  output logic raw_rotate_ccw,
  output logic raw_drop,
  output logic raw_hold,
  output logic frame_err
);

  logic [BYTE_W-1:0]   rx_byte;
  logic                rx_valid;
  dec_state_e          state;
  dec_state_e          state_next;
  logic [NUM_KEYS-1:0] held;
  logic [NUM_KEYS-1:0] held_next;
  logic                is_ext_c;
  logic                is_brk_c;
  key_lookup_t         lk_c;

  ps2_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .byte_out  (rx_byte),
    .byte_valid(rx_valid),
    .frame_err (frame_err)
  );

  assign is_ext_c = (state == ST_EXT) || (state == ST_EXT_BRK);
  assign is_brk_c = (state == ST_BRK) || (state == ST_EXT_BRK);
  assign lk_c     = lookup_key(is_ext_c, rx_byte);

  // Decoder state register and key/output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      held           <= '0;
      raw_left       <= 1'b0;
      raw_right      <= 1'b0;
      raw_down       <= 1'b0;
      raw_rotate_cw  <= 1'b0;
      raw_rotate_ccw <= 1'b0;
      raw_drop       <= 1'b0;
      raw_hold       <= 1'b0;
    end else begin
      state          <= state_next;
      held           <= held_next;
      raw_left       <= held_next[KEY_LEFT];
      raw_right      <= held_next[KEY_RIGHT];
      raw_down       <= held_next[KEY_DOWN];
      raw_rotate_cw  <= held_next[KEY_UP] | held_next[KEY_X];
      raw_rotate_ccw <= held_next[KEY_Z];
      raw_drop       <= held_next[KEY_SPACE];
      raw_hold       <= held_next[KEY_C];
    end
  end

  // Next-state and key-state update on each received byte
  always_comb begin
    state_next = state;
    held_next  = held;
    if (frame_err) begin
      state_next = ST_IDLE;
    end else if (rx_valid) begin
      case (rx_byte)
        SC_ACK: begin
          state_next = state;
        end
        SC_EXT: begin
          // A fresh E0 always restarts an extended sequence
          state_next = ST_EXT;
        end
        SC_BRK: begin
          if (state == ST_IDLE) begin
            state_next = ST_BRK;
          end else if (state == ST_EXT) begin
            state_next = ST_EXT_BRK;
          end
        end
        default: begin
          state_next = ST_IDLE;
          if ((state == ST_IDLE) &&
              ((rx_byte == SC_BAT_OK) || (rx_byte == SC_ERR_ZERO) ||
               (rx_byte == SC_OVERRUN))) begin
            held_next = '0;
          end else if (lk_c.hit) begin
            held_next[lk_c.idx] = ~is_brk_c;
          end
        end
      endcase
    end
  end

endmodule
